// File: rtl/pipe_stage_buf_if.sv
// Valid/ready handshake bundle between adjacent pipeline stages, plus flush and
// monitoring outputs of one pipe_stage_buf instance.
interface pipe_stage_buf_if #(
   parameter int DATA_WIDTH = 325,
   parameter int CTRL_WIDTH = 25,
   parameter int CNT_WIDTH  = 16
);
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic [CTRL_WIDTH-1:0] in_ctrl;
   logic                  out_ready;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic [CTRL_WIDTH-1:0] out_ctrl;
   logic                  in_ready;
   logic                  in_flush;
   logic [1:0]            out_occupancy;
   logic [CNT_WIDTH-1:0]  out_stall_count;

   modport slave (
      input  in_valid, in_data, in_ctrl, in_ready, in_flush,
      output out_ready, out_valid, out_data, out_ctrl, out_occupancy, out_stall_count
   );

   modport master (
      output in_valid, in_data, in_ctrl, in_ready, in_flush,
      input  out_ready, out_valid, out_data, out_ctrl, out_occupancy, out_stall_count
   );
endinterface

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage buffer: main slot plus skid slot, synchronous flush,
// bubble control on empty, saturating back-pressure counter.
//
// state    | meaning
// ST_EMPTY | no entry held, out_valid=0, out_ctrl=CTRL_BUBBLE
// ST_BUSY  | main slot holds the head entry
// ST_FULL  | main holds head, skid holds the younger entry, out_ready=0
module pipe_stage_buf #(
   parameter int                  DATA_WIDTH  = 325,
   parameter int                  CTRL_WIDTH  = 25,
   parameter logic [CTRL_WIDTH-1:0] CTRL_BUBBLE = {CTRL_WIDTH{1'b0}},
   parameter int                  CNT_WIDTH   = 16
) (
   input logic Clk,
   input logic Rst,
   pipe_stage_buf_if.slave bus
);
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_BUSY  = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]            state;
   logic [1:0]            state_nxt;
   logic [DATA_WIDTH-1:0] main_data, skid_data;
   logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl;
   logic [CNT_WIDTH-1:0]  stall_cnt;
   logic                  accept, drain;
   logic                  load_main_in, load_main_skid, load_skid;

   assign accept = bus.in_valid & bus.out_ready;
   assign drain  = bus.out_valid & bus.in_ready;

   always_comb begin
      state_nxt      = state;
      load_main_in   = 1'b0;
      load_main_skid = 1'b0;
      load_skid      = 1'b0;
      case (state)
         ST_EMPTY: begin
            if (accept) begin
               load_main_in = 1'b1;
               state_nxt    = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (accept && drain) begin
               load_main_in = 1'b1;
            end else if (accept) begin
               load_skid = 1'b1;
               state_nxt = ST_FULL;
            end else if (drain) begin
               state_nxt = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               load_main_skid = 1'b1;
               state_nxt      = ST_BUSY;
            end
         end
         default: state_nxt = ST_EMPTY;
      endcase
      // flush overrides everything and leaves both slots untouched
      if (bus.in_flush) begin
         state_nxt      = ST_EMPTY;
         load_main_in   = 1'b0;
         load_main_skid = 1'b0;
         load_skid      = 1'b0;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state <= ST_EMPTY;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         main_data <= '0;
         main_ctrl <= '0;
         skid_data <= '0;
         skid_ctrl <= '0;
      end else begin
         if (load_main_in) begin
            main_data <= bus.in_data;
            main_ctrl <= bus.in_ctrl;
         end else if (load_main_skid) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
         end
         if (load_skid) begin
            skid_data <= bus.in_data;
            skid_ctrl <= bus.in_ctrl;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         stall_cnt <= '0;
      end else if (bus.out_valid && !bus.in_ready && stall_cnt != {CNT_WIDTH{1'b1}}) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

   // state encoding doubles as the entry count
   assign bus.out_valid       = (state != ST_EMPTY);
   assign bus.out_ready       = (state != ST_FULL);
   assign bus.out_data        = main_data;
   assign bus.out_ctrl        = bus.out_valid ? main_ctrl : CTRL_BUBBLE;
   assign bus.out_occupancy   = state;
   assign bus.out_stall_count = stall_cnt;
endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (default and 4-bit stall counter)
// driven in lockstep and compared against a queue-based reference model.
module tb_pipe_stage_buf;
   localparam int DW = 325;
   localparam int CW = 25;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
   } ent_t;

   logic Clk = 1'b0;
   logic Rst = 1'b1;
   always #5 Clk = ~Clk;

   pipe_stage_buf_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(16)) bus_a ();
   pipe_stage_buf_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(4))  bus_b ();

   pipe_stage_buf #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(16)) dut_a (
      .Clk(Clk), .Rst(Rst), .bus(bus_a.slave));
   pipe_stage_buf #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CNT_WIDTH(4)) dut_b (
      .Clk(Clk), .Rst(Rst), .bus(bus_b.slave));

   int n_vec = 0;
   int n_err = 0;

   logic          s_valid, s_ready, s_flush;
   logic [DW-1:0] s_data;
   logic [CW-1:0] s_ctrl;

   ent_t          q[$];
   logic [DW-1:0] m_data;
   int            m_cnt_a, m_cnt_b;

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic r, input logic f);
      s_valid = v; s_data = d; s_ctrl = c; s_ready = r; s_flush = f;
      bus_a.in_valid = v; bus_a.in_data = d; bus_a.in_ctrl = c;
      bus_a.in_ready = r; bus_a.in_flush = f;
      bus_b.in_valid = v; bus_b.in_data = d; bus_b.in_ctrl = c;
      bus_b.in_ready = r; bus_b.in_flush = f;
   endtask

   task automatic model_reset();
      q.delete();
      m_data  = '0;
      m_cnt_a = 0;
      m_cnt_b = 0;
   endtask

   // one clock edge of the behavioural stage
   task automatic model_update();
      bit   acc, drn;
      ent_t e;
      acc = s_valid && (q.size() < 2);
      drn = (q.size() > 0) && s_ready;
      if (q.size() > 0 && !s_ready) begin
         if (m_cnt_a < 65535) m_cnt_a++;
         if (m_cnt_b < 15)    m_cnt_b++;
      end
      if (s_flush) begin
         q.delete();
      end else begin
         if (drn) void'(q.pop_front());
         if (acc) begin
            e.d = s_data;
            e.c = s_ctrl;
            q.push_back(e);
         end
      end
      if (q.size() > 0) m_data = q[0].d;
   endtask

   task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [CW-1:0] e_ctrl;
      e_ctrl = (q.size() > 0) ? q[0].c : '0;
      chk("a_valid", DW'(bus_a.out_valid),       DW'(q.size() != 0));
      chk("a_ready", DW'(bus_a.out_ready),       DW'(q.size() != 2));
      chk("a_data",  bus_a.out_data,             m_data);
      chk("a_ctrl",  DW'(bus_a.out_ctrl),        DW'(e_ctrl));
      chk("a_occ",   DW'(bus_a.out_occupancy),   DW'(q.size()));
      chk("a_stall", DW'(bus_a.out_stall_count), DW'(m_cnt_a));
      chk("b_valid", DW'(bus_b.out_valid),       DW'(q.size() != 0));
      chk("b_data",  bus_b.out_data,             m_data);
      chk("b_ctrl",  DW'(bus_b.out_ctrl),        DW'(e_ctrl));
      chk("b_stall", DW'(bus_b.out_stall_count), DW'(m_cnt_b));
   endtask

   task automatic step();
      @(posedge Clk);
      if (!Rst) model_update();
      @(negedge Clk);
      check_all();
   endtask

   function automatic logic [DW-1:0] rand_data();
      logic [DW-1:0] d;
      d = '0;
      for (int k = 0; k < 11; k++) d = {d[DW-33:0], 32'($urandom())};
      return d;
   endfunction

   initial begin
      model_reset();
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge Clk);
      check_all();
      Rst = 1'b0;
      step();

      // stream 8 back-to-back entries
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, DW'(i), CW'(i + 1), 1'b1, 1'b0);
         step();
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      step();
      chk("stream_stall", DW'(bus_a.out_stall_count), DW'(0));

      // back-pressure: A, then B captured while in_ready low, C held off
      drive(1'b1, DW'(16'hA), CW'(16'hA1), 1'b1, 1'b0); step();
      drive(1'b1, DW'(16'hB), CW'(16'hB1), 1'b0, 1'b0); step();
      chk("bp_occ_full", DW'(bus_a.out_occupancy), DW'(2));
      drive(1'b1, DW'(16'hC), CW'(16'hC1), 1'b0, 1'b0); step(); step();
      drive(1'b1, DW'(16'hC), CW'(16'hC1), 1'b1, 1'b0); step();
      drive(1'b0, '0, '0, 1'b1, 1'b0); step(); step(); step();

      // flush while full with C offered
      drive(1'b1, DW'(16'h1A), CW'(16'h1A), 1'b0, 1'b0); step(); step();
      drive(1'b1, DW'(16'h1C), CW'(16'h1C), 1'b0, 1'b1); step();
      chk("flush_occ",  DW'(bus_a.out_occupancy), DW'(0));
      chk("flush_ctrl", DW'(bus_a.out_ctrl),      DW'(0));

      // idle empty stage
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step();

      // saturate the 4-bit counter
      drive(1'b1, DW'(16'h55), CW'(16'h55), 1'b0, 1'b0); step();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step();
      chk("sat_small", DW'(bus_b.out_stall_count), DW'(15));
      drive(1'b0, '0, '0, 1'b1, 1'b0); step();

      // async reset between edges while full
      drive(1'b1, DW'(16'h77), CW'(16'h77), 1'b0, 1'b0); step(); step();
      chk("pre_rst_occ", DW'(bus_a.out_occupancy), DW'(2));
      #2 Rst = 1'b1;
      #1 model_reset();
      check_all();
      #1 Rst = 1'b0;
      drive(1'b1, DW'(16'h99), CW'(16'h99), 1'b1, 1'b0); step();
      chk("post_rst_valid", DW'(bus_a.out_valid), DW'(1));
      chk("post_rst_data",  bus_a.out_data,       DW'(16'h99));

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         drive(1'($urandom_range(0, 3) != 0), rand_data(), CW'($urandom()),
               1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
